// File: rtl/clock_rate_ctrl.sv
// clock_rate_ctrl
//   Selects the modulus of a downstream mod-k counter so that the divided clock
//   runs at 0.1 Hz, 1 Hz or 10 Hz, or stops. A change of rate waits for the
//   counter's roll-over. This keeps the old period intact, so the divided clock
//   is never cut short. After the roll-over the new modulus is loaded and the
//   counter is restarted.
//
// Ports
//   i_clk            system clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_req            rate-change request, only accepted in IDLE
//   i_sel[1:0]       requested rate: 0=0.1 Hz, 1=1 Hz, 2=10 Hz, 3=stop
//   i_roll_over      period-boundary pulse from the driven counter
//   o_k[N-1:0]       modulus presented to the driven counter
//   o_counter_reset  one-cycle restart pulse to the counter and toggle stage
//   o_clk_en         1 = divided clock running, 0 = stopped
//   o_sel_cur[1:0]   currently applied rate code
//   o_busy           high in every state except IDLE
//   o_ack            one-cycle completion pulse per accepted request
//   o_drop           one-cycle pulse for a request that arrived while busy
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request
// PEND  | new code latched, waiting for the counter's period boundary
// LOAD  | new modulus applied, counter restart pulse asserted (one cycle)
// ACK   | completion pulse (one cycle)

module clock_rate_ctrl #(
    parameter int unsigned N     = 28,
    parameter int unsigned K_0_1 = 250000000,
    parameter int unsigned K_1   = 25000000,
    parameter int unsigned K_10  = 2500000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req,
    input  logic [1:0]   i_sel,
    input  logic         i_roll_over,
    output logic [N-1:0] o_k,
    output logic         o_counter_reset,
    output logic         o_clk_en,
    output logic [1:0]   o_sel_cur,
    output logic         o_busy,
    output logic         o_ack,
    output logic         o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_LOAD = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_STOP = 2'd3;

    state_t     state;
    logic [1:0] sel_pend;

    // Code 3 (stop) never reaches this function; it keeps the previous modulus.
    function automatic logic [N-1:0] k_for(input logic [1:0] sel);
        case (sel)
            2'd0:    k_for = N'(K_0_1);
            2'd2:    k_for = N'(K_10);
            default: k_for = N'(K_1);
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            sel_pend        <= 2'd1;
            o_k             <= N'(K_1);
            o_sel_cur       <= 2'd1;
            o_clk_en        <= 1'b1;
            o_busy          <= 1'b0;
            o_ack           <= 1'b0;
            o_drop          <= 1'b0;
            // Restart the counter so that it agrees with the reset modulus.
            o_counter_reset <= 1'b1;
        end else begin
            o_ack           <= 1'b0;
            o_counter_reset <= 1'b0;
            // o_busy is registered and mirrors state != IDLE, so a request
            // that meets o_busy=1 is exactly a request the FSM ignores.
            o_drop          <= i_req & o_busy;

            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        sel_pend <= i_sel;
                        o_busy   <= 1'b1;
                        if (i_sel == o_sel_cur) begin
                            state <= ST_ACK;
                            o_ack <= 1'b1;
                        end else begin
                            state <= ST_PEND;
                        end
                    end
                end

                ST_PEND: begin
                    // A stopped counter never rolls over, so do not wait for it.
                    if (i_roll_over || (o_sel_cur == SEL_STOP)) begin
                        state           <= ST_LOAD;
                        o_counter_reset <= 1'b1;
                        o_sel_cur       <= sel_pend;
                        if (sel_pend == SEL_STOP) begin
                            o_clk_en <= 1'b0;
                        end else begin
                            o_clk_en <= 1'b1;
                            o_k      <= k_for(sel_pend);
                        end
                    end
                end

                ST_LOAD: begin
                    state <= ST_ACK;
                    o_ack <= 1'b1;
                end

                ST_ACK: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_rate_ctrl.sv
module tb_clock_rate_ctrl;

    localparam int N = 28;
    localparam logic [N-1:0] K01 = 28'd250000000;
    localparam logic [N-1:0] K1  = 28'd25000000;
    localparam logic [N-1:0] K10 = 28'd2500000;

    logic         clk;
    logic         reset;
    logic         req;
    logic [1:0]   sel;
    logic         roll_over;
    logic [N-1:0] k;
    logic         counter_reset;
    logic         clk_en;
    logic [1:0]   sel_cur;
    logic         busy;
    logic         ack;
    logic         drop;

    int checks   = 0;
    int failures = 0;

    clock_rate_ctrl #(
        .N    (N),
        .K_0_1(250000000),
        .K_1  (25000000),
        .K_10 (2500000)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req          (req),
        .i_sel          (sel),
        .i_roll_over    (roll_over),
        .o_k            (k),
        .o_counter_reset(counter_reset),
        .o_clk_en       (clk_en),
        .o_sel_cur      (sel_cur),
        .o_busy         (busy),
        .o_ack          (ack),
        .o_drop         (drop)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Step past the next rising edge; outputs are then stable for sampling
    // and inputs set now are seen by the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; sel = 2'd0; roll_over = 1'b0;
        tick();
        tick();
        checks++; if (k !== K1) begin failures++; $display("FAIL reset_k: got %0d want %0d", k, K1); end
        checks++; if (sel_cur !== 2'd1) begin failures++; $display("FAIL reset_sel_cur: got %0d want 1", sel_cur); end
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL reset_clk_en: got %b want 1", clk_en); end
        checks++; if (busy !== 1'b0 || ack !== 1'b0 || drop !== 1'b0) begin failures++; $display("FAIL reset_flags: busy=%b ack=%b drop=%b want 0 0 0", busy, ack, drop); end
        checks++; if (counter_reset !== 1'b1) begin failures++; $display("FAIL reset_counter_reset: got %b want 1", counter_reset); end
        reset = 1'b0;
        tick();
        checks++; if (counter_reset !== 1'b0) begin failures++; $display("FAIL reset_release_cr: got %b want 0", counter_reset); end
    endtask

    task automatic test_same_code();
        req = 1'b1; sel = 2'd1;
        tick();
        req = 1'b0;
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL same_ack: got %b want 1", ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL same_busy: got %b want 1", busy); end
        checks++; if (counter_reset !== 1'b0) begin failures++; $display("FAIL same_cr: got %b want 0", counter_reset); end
        checks++; if (k !== K1) begin failures++; $display("FAIL same_k: got %0d want %0d", k, K1); end
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0 || counter_reset !== 1'b0) begin failures++; $display("FAIL same_after: ack=%b busy=%b cr=%b want 0 0 0", ack, busy, counter_reset); end
    endtask

    task automatic test_roll_ignored();
        roll_over = 1'b1;
        tick();
        roll_over = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || counter_reset !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL idle_roll: busy=%b cr=%b ack=%b want 0 0 0", busy, counter_reset, ack); end
        checks++; if (k !== K1 || sel_cur !== 2'd1) begin failures++; $display("FAIL idle_roll_k: k=%0d sel=%0d want %0d 1", k, sel_cur, K1); end
    endtask

    // Request 1 -> 2, roll-over sampled 5 edges after the request.
    task automatic test_new_code();
        int busy_cycles;
        busy_cycles = 0;
        req = 1'b1; sel = 2'd2;
        tick();
        req = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            if (busy === 1'b1) busy_cycles++;
            if (p <= 5) begin
                checks++; if (k !== K1) begin failures++; $display("FAIL new_k_hold p=%0d: got %0d want %0d", p, k, K1); end
            end
            checks++; if (counter_reset !== (p == 6)) begin failures++; $display("FAIL new_cr p=%0d: got %b want %b", p, counter_reset, (p == 6)); end
            checks++; if (ack !== (p == 7)) begin failures++; $display("FAIL new_ack p=%0d: got %b want %b", p, ack, (p == 7)); end
            if (p == 6) begin
                checks++; if (k !== K10) begin failures++; $display("FAIL new_load_k: got %0d want %0d", k, K10); end
                checks++; if (sel_cur !== 2'd2) begin failures++; $display("FAIL new_sel_cur: got %0d want 2", sel_cur); end
            end
            roll_over = (p == 5);
            tick();
        end
        roll_over = 1'b0;
        checks++; if (busy_cycles != 7) begin failures++; $display("FAIL new_busy_cycles: got %0d want 7", busy_cycles); end
    endtask

    // 2 -> 3 (stop) with a roll-over, then 3 -> 0 without any roll-over.
    task automatic test_stop_start();
        req = 1'b1; sel = 2'd3;
        tick();
        req = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            if (p == 2) begin
                checks++; if (counter_reset !== 1'b1 || clk_en !== 1'b0 || sel_cur !== 2'd3) begin failures++; $display("FAIL stop_load: cr=%b en=%b sel=%0d want 1 0 3", counter_reset, clk_en, sel_cur); end
                checks++; if (k !== K10) begin failures++; $display("FAIL stop_k: got %0d want %0d", k, K10); end
            end
            if (p == 3) begin
                checks++; if (ack !== 1'b1) begin failures++; $display("FAIL stop_ack: got %b want 1", ack); end
            end
            roll_over = (p == 1);
            tick();
        end
        roll_over = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_idle: busy got %b want 0", busy); end
        req = 1'b1; sel = 2'd0;
        tick();
        req = 1'b0;
        checks++; if (busy !== 1'b1 || counter_reset !== 1'b0 || clk_en !== 1'b0) begin failures++; $display("FAIL start_pend: busy=%b cr=%b en=%b want 1 0 0", busy, counter_reset, clk_en); end
        tick();
        checks++; if (counter_reset !== 1'b1) begin failures++; $display("FAIL start_load_cr: got %b want 1", counter_reset); end
        checks++; if (k !== K01) begin failures++; $display("FAIL start_load_k: got %0d want %0d", k, K01); end
        checks++; if (clk_en !== 1'b1 || sel_cur !== 2'd0) begin failures++; $display("FAIL start_load_en: en=%b sel=%0d want 1 0", clk_en, sel_cur); end
        tick();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL start_ack: got %b want 1", ack); end
        tick();
    endtask

    // 0 -> 2 pending, reset (with a coincident roll-over) abandons it.
    task automatic test_reset_in_pend();
        req = 1'b1; sel = 2'd2;
        tick();
        req = 1'b0;
        tick();
        checks++; if (busy !== 1'b1 || k !== K01) begin failures++; $display("FAIL rp_pend: busy=%b k=%0d want 1 %0d", busy, k, K01); end
        reset = 1'b1; roll_over = 1'b1;
        tick();
        reset = 1'b0; roll_over = 1'b0;
        checks++; if (busy !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL rp_idle: busy=%b ack=%b want 0 0", busy, ack); end
        checks++; if (k !== K1 || sel_cur !== 2'd1) begin failures++; $display("FAIL rp_k: k=%0d sel=%0d want %0d 1", k, sel_cur, K1); end
        checks++; if (counter_reset !== 1'b1 || clk_en !== 1'b1) begin failures++; $display("FAIL rp_cr: cr=%b en=%b want 1 1", counter_reset, clk_en); end
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0 || counter_reset !== 1'b0) begin failures++; $display("FAIL rp_after: ack=%b busy=%b cr=%b want 0 0 0", ack, busy, counter_reset); end
    endtask

    // 1 -> 0 with i_req held through the busy period and i_sel changed to 2.
    task automatic test_back_to_back();
        int acks;
        int drops;
        acks = 0; drops = 0;
        req = 1'b1; sel = 2'd0;
        tick();
        sel = 2'd2;
        for (int p = 1; p <= 9; p++) begin
            if (ack === 1'b1) acks++;
            if (drop === 1'b1) drops++;
            checks++; if (drop !== (p >= 2 && p <= 6)) begin failures++; $display("FAIL b2b_drop p=%0d: got %b want %b", p, drop, (p >= 2 && p <= 6)); end
            if (p == 4) begin
                checks++; if (counter_reset !== 1'b1 || sel_cur !== 2'd0 || k !== K01) begin failures++; $display("FAIL b2b_load: cr=%b sel=%0d k=%0d want 1 0 %0d", counter_reset, sel_cur, k, K01); end
            end
            req = (p <= 5);
            roll_over = (p == 3);
            tick();
        end
        req = 1'b0; roll_over = 1'b0;
        checks++; if (acks != 1) begin failures++; $display("FAIL b2b_acks: got %0d want 1", acks); end
        checks++; if (drops != 5) begin failures++; $display("FAIL b2b_drops: got %0d want 5", drops); end
        checks++; if (sel_cur !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_final: sel=%0d busy=%b want 0 0", sel_cur, busy); end
    endtask

    task automatic test_req_with_reset();
        req = 1'b1; sel = 2'd2; reset = 1'b1;
        tick();
        req = 1'b0; reset = 1'b0;
        checks++; if (ack !== 1'b0 || drop !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rr_flags: ack=%b drop=%b busy=%b want 0 0 0", ack, drop, busy); end
        checks++; if (sel_cur !== 2'd1 || k !== K1) begin failures++; $display("FAIL rr_state: sel=%0d k=%0d want 1 %0d", sel_cur, k, K1); end
        tick();
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rr_after: ack=%b busy=%b want 0 0", ack, busy); end
    endtask

    initial begin
        test_reset();
        test_same_code();
        test_roll_ignored();
        test_new_code();
        test_stop_start();
        test_reset_in_pend();
        test_back_to_back();
        test_req_with_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
